// File: rtl/aibcr3_rxdeser_pkg.sv
// Shared state type, default alignment word and sizing helper for the AIB RX word deserializer.
package aibcr3_rxdeser_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rxdeser_state_e;

    localparam logic [19:0] SYNC_PAT_DEFAULT = 20'hF0C5A;

    // Width of a counter that steps through the DATA_W/2 bit pairs of one word.
    function automatic int phase_w(input int data_w);
        return (data_w / 2 > 1) ? $clog2(data_w / 2) : 1;
    endfunction

endpackage

// File: rtl/aibcr3_rxdat_deser_if.sv
// Data/status bundle between the AIB RX IO buffer side and the word deserializer.
// oerr_cnt is present only when AIBCR3_RXDESER_ERRCNT_EN is defined.
interface aibcr3_rxdat_deser_if #(
    parameter int DATA_W = 20
);
    logic              idat0;
    logic              idat1;
    logic              ialign_req;
    logic [DATA_W-1:0] oword;
    logic              ovld;
    logic              olocked;
    logic              oalign_odd;
    logic              ochk_err;
`ifdef AIBCR3_RXDESER_ERRCNT_EN
    logic [7:0]        oerr_cnt;

    modport master (
        output idat0, idat1, ialign_req,
        input  oword, ovld, olocked, oalign_odd, ochk_err, oerr_cnt
    );

    modport slave (
        input  idat0, idat1, ialign_req,
        output oword, ovld, olocked, oalign_odd, ochk_err, oerr_cnt
    );
`else
    modport master (
        output idat0, idat1, ialign_req,
        input  oword, ovld, olocked, oalign_odd, ochk_err
    );

    modport slave (
        input  idat0, idat1, ialign_req,
        output oword, ovld, olocked, oalign_odd, ochk_err
    );
`endif
endinterface

// File: rtl/aibcr3_rxdeser_shreg.sv
// Bit-pair history register with both word-boundary candidates and their sync-word comparators.
module aibcr3_rxdeser_shreg
    import aibcr3_rxdeser_pkg::*;
#(
    parameter int                DATA_W   = 20,
    parameter logic [DATA_W-1:0] SYNC_PAT = DATA_W'(SYNC_PAT_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dat0_i,
    input  logic              dat1_i,
    output logic [DATA_W-1:0] cand_even_o,
    output logic [DATA_W-1:0] cand_odd_o,
    output logic              match_even_o,
    output logic              match_odd_o
);

    logic [DATA_W:0] hist_q;

    // Newest pair enters at the top, so the oldest bit of a candidate lands in bit 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= {dat1_i, dat0_i, hist_q[DATA_W:2]};
        end
    end

    assign cand_even_o  = hist_q[DATA_W:1];
    assign cand_odd_o   = hist_q[DATA_W-1:0];
    assign match_even_o = (cand_even_o == SYNC_PAT);
    assign match_odd_o  = (cand_odd_o == SYNC_PAT);

endmodule

// File: rtl/aibcr3_rxdat_deser.sv
// AIB RX word deserializer/aligner: hunts for SYNC_PAT, confirms it SYNC_CNT times, then emits words.
// Optional saturating mismatch counter oerr_cnt is enabled by AIBCR3_RXDESER_ERRCNT_EN.
module aibcr3_rxdat_deser
    import aibcr3_rxdeser_pkg::*;
#(
    parameter int                DATA_W   = 20,
    parameter logic [DATA_W-1:0] SYNC_PAT = DATA_W'(SYNC_PAT_DEFAULT),
    parameter int                SYNC_CNT = 4
) (
    input  logic                istrbclk,
    input  logic                irstb,
    aibcr3_rxdat_deser_if.slave rx
);

    localparam int                 HALF       = DATA_W / 2;
    localparam int                 PHASE_W    = phase_w(DATA_W);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF - 1);
    localparam logic [3:0]         CNT_LOCK   = 4'(SYNC_CNT);

    rxdeser_state_e     state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               vld_q, vld_d;
    logic               odd_q, odd_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  cand_even, cand_odd, cand_sel;
    logic               match_even, match_odd;
    logic               boundary;

    aibcr3_rxdeser_shreg #(
        .DATA_W   (DATA_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_shreg (
        .clk_i        (istrbclk),
        .rst_n_i      (irstb),
        .dat0_i       (rx.idat0),
        .dat1_i       (rx.idat1),
        .cand_even_o  (cand_even),
        .cand_odd_o   (cand_odd),
        .match_even_o (match_even),
        .match_odd_o  (match_odd)
    );

    assign cand_sel = odd_q ? cand_odd : cand_even;
    assign boundary = (phase_q == PHASE_LAST);

    // A sync hit in HUNT means a full word sits in the history now, so phase restarts at 0
    // and the next full word is seen exactly HALF cycles later.
    always_comb begin
        state_d = state_q;
        phase_d = boundary ? '0 : phase_q + PHASE_W'(1);
        cnt_d   = cnt_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        odd_d   = odd_q;
        err_d   = 1'b0;

        if (rx.ialign_req) begin
            state_d = HUNT;
            cnt_d   = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (match_even || match_odd) begin
                        odd_d   = !match_even;
                        cnt_d   = 4'd1;
                        phase_d = '0;
                        state_d = (SYNC_CNT == 1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        if (cand_sel == SYNC_PAT) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_d == CNT_LOCK) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        word_d = cand_sel;
                        vld_d  = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge istrbclk or negedge irstb) begin
        if (!irstb) begin
            state_q <= HUNT;
            phase_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            odd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            odd_q   <= odd_d;
            err_q   <= err_d;
        end
    end

    assign rx.oword      = word_q;
    assign rx.ovld       = vld_q;
    assign rx.olocked    = (state_q == LOCKED);
    assign rx.oalign_odd = odd_q;
    assign rx.ochk_err   = err_q;

`ifdef AIBCR3_RXDESER_ERRCNT_EN
    logic [7:0] errcnt_q;

    // Survives realignment on purpose; only irstb clears the running total.
    always_ff @(posedge istrbclk or negedge irstb) begin
        if (!irstb) begin
            errcnt_q <= '0;
        end else if (err_d && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign rx.oerr_cnt = errcnt_q;
`endif

endmodule
